// File: rtl/tiny_core_mc_if.sv
// Instruction-fetch handshake between tiny_core_mc and its instruction memory.
// The core drives the request and word address; the memory returns ack and data.
interface tiny_core_mc_if #(
  parameter int unsigned ROM_ADDR_BITS = 4
);
  logic                     imem_req;
  logic [ROM_ADDR_BITS-1:0] imem_addr;
  logic                     imem_ack;
  logic [31:0]              imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/tiny_core_mc.sv
// Minimal multi-cycle RV32-subset core: FETCH/EXEC/HALT, a small register file,
// GPIO mapped to load/store, and a 16-bit retired-instruction counter.
module tiny_core_mc #(
  parameter int unsigned ROM_ADDR_BITS = 4,
  parameter int unsigned REG_ADDR_BITS = 3,
  parameter int unsigned GPIO_W        = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tiny_core_mc_if.master       imem,
  input  logic [GPIO_W-1:0]    gpio_in,
  output logic [GPIO_W-1:0]    gpio_out,
  output logic                 halted,
  output logic [15:0]          instret
);

  localparam int unsigned PC_W  = ROM_ADDR_BITS + 2;
  localparam int unsigned NREGS = 1 << REG_ADDR_BITS;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    HALT
  } state_e;

  state_e                   state_q, state_d;
  logic [PC_W-1:0]          pc_q, pc_d;
  logic [31:0]              ir_q, ir_d;
  logic [31:0]              regs_q [NREGS];
  logic [31:0]              regs_d [NREGS];
  logic [GPIO_W-1:0]        gpio_q, gpio_d;
  logic [15:0]              instret_q, instret_d;

  logic [6:0]               opcode;
  logic [2:0]               funct3;
  logic [6:0]               funct7;
  logic [REG_ADDR_BITS-1:0] rd, rs1, rs2;
  logic [31:0]              rs1_val, rs2_val;
  logic [31:0]              imm_i, imm_b;
  logic [31:0]              alu_b, alu_res;
  logic                     alu_ok;
  logic                     br_taken;
  logic [31:0]              gpio_ext;
  logic                     wr_en;
  logic [31:0]              wr_data;
  logic                     unused_ir;

  always_comb begin
    opcode  = ir_q[6:0];
    funct3  = ir_q[14:12];
    funct7  = ir_q[31:25];
    rd      = ir_q[7 +: REG_ADDR_BITS];
    rs1     = ir_q[15 +: REG_ADDR_BITS];
    rs2     = ir_q[20 +: REG_ADDR_BITS];
    rs1_val = regs_q[rs1];
    rs2_val = regs_q[rs2];
    imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
    imm_b   = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    gpio_ext = '0;
    gpio_ext[GPIO_W-1:0] = gpio_in;
  end

  assign unused_ir = ^{ir_q[19:15], imm_b};

  // Shared ALU for R-type and I-type; unrecognised funct encodings write nothing.
  always_comb begin
    alu_b   = (opcode == OP_R) ? rs2_val : imm_i;
    alu_res = '0;
    alu_ok  = 1'b1;
    case (funct3)
      3'b000: begin
        if (opcode == OP_I || funct7 == 7'b0000000) begin
          alu_res = rs1_val + alu_b;
        end else if (funct7 == 7'b0100000) begin
          alu_res = rs1_val - alu_b;
        end else begin
          alu_ok = 1'b0;
        end
      end
      3'b111:  alu_res = rs1_val & alu_b;
      3'b110:  alu_res = rs1_val | alu_b;
      3'b100:  alu_res = rs1_val ^ alu_b;
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    regs_d    = regs_q;
    gpio_d    = gpio_q;
    instret_d = instret_q;
    wr_en     = 1'b0;
    wr_data   = '0;
    case (state_q)
      FETCH: begin
        if (imem.imem_ack) begin
          ir_d    = imem.imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        instret_d = instret_q + 16'd1;
        pc_d      = pc_q + PC_W'(4);
        state_d   = FETCH;
        case (opcode)
          OP_R, OP_I: begin
            wr_en   = alu_ok;
            wr_data = alu_res;
          end
          OP_B: begin
            if (br_taken) pc_d = pc_q + imm_b[PC_W-1:0];
          end
          OP_LOAD: begin
            wr_en   = 1'b1;
            wr_data = gpio_ext;
          end
          OP_STORE: gpio_d = rs2_val[GPIO_W-1:0];
          default:  state_d = HALT;
        endcase
        pc_d[1:0] = 2'b00;
        if (wr_en && rd != '0) regs_d[rd] = wr_data;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      gpio_q    <= '0;
      instret_q <= '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      regs_q    <= regs_d;
      gpio_q    <= gpio_d;
      instret_q <= instret_d;
    end
  end

  // Gated by rst_n so no fetch is requested during a cycle held in reset.
  assign imem.imem_req  = (state_q == FETCH) && rst_n;
  assign imem.imem_addr = pc_q[PC_W-1:2];
  assign gpio_out       = gpio_q;
  assign halted         = (state_q == HALT);
  assign instret        = instret_q;

endmodule

// File: doc/tiny_core_mc.md
TINY_CORE_MC -- requirements
Module: tiny_core_mc

Interface
REQ-001 Parameter ROM_ADDR_BITS, default 4: instruction-memory word-address width; PC width is ROM_ADDR_BITS+2.
REQ-002 Parameter REG_ADDR_BITS, default 3: register-file index width; 2**REG_ADDR_BITS registers of 32 bits.
REQ-003 Parameter GPIO_W, default 8, range 1..32: GPIO port width.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1: reset, synchronous and active-low.
REQ-006 Port imem_req  output  1: instruction fetch request.
REQ-007 Port imem_addr  output  ROM_ADDR_BITS: word address of the fetch, equal to pc[ROM_ADDR_BITS+1:2].
REQ-008 Port imem_ack  input  1: fetch data valid this cycle.
REQ-009 Port imem_rdata  input  32: instruction word, sampled only when imem_req and imem_ack are both high.
REQ-010 Port gpio_in  input  GPIO_W: general-purpose input.
REQ-011 Port gpio_out  output  GPIO_W: registered general-purpose output.
REQ-012 Port halted  output  1: core stopped in HALT.
REQ-013 Port instret  output  16: retired-instruction count, wraps at 2**16.

Function
REQ-014 FSM states: FETCH, EXEC, HALT; imem_req SHALL be high only in FETCH.
REQ-015 FETCH: imem_req=1, imem_addr stable; on imem_ack latch imem_rdata into IR and go to EXEC the next cycle; without imem_ack stay in FETCH indefinitely.
REQ-016 EXEC lasts exactly one cycle: execute IR, update PC and registers, increment instret, then go to FETCH (or HALT per REQ-023); minimum 2 cycles per instruction.
REQ-017 R-type (opcode 0110011): funct3 000 = ADD (funct7 0000000) / SUB (funct7 0100000); 111 = AND; 110 = OR; 100 = XOR; rd = rs1 op rs2.
REQ-018 I-type ALU (opcode 0010011): ADDI, ANDI, ORI, XORI using the same funct3 codes, with a sign-extended 12-bit immediate.
REQ-019 Branch (opcode 1100011): funct3 000 = BEQ, 001 = BNE; if taken, pc = pc + sign-extended B-immediate, else pc = pc + 4.
REQ-020 Load (opcode 0000011, any funct3/address): rd = zero-extended gpio_in, sampled in the EXEC cycle.
REQ-021 Store (opcode 0100011, any funct3/address): gpio_out <= rs2[GPIO_W-1:0] at the end of EXEC; gpio_out holds otherwise.
REQ-022 Register indices use the low REG_ADDR_BITS bits of rd/rs1/rs2; register 0 reads 0 and ignores writes.
REQ-023 EBREAK (32'h00100073) and any opcode not listed above: no register/GPIO write; instret increments; the FSM enters HALT, which it leaves only on reset.
REQ-024 PC arithmetic is modulo 2**(ROM_ADDR_BITS+2); pc[1:0] is forced to 0; sequential execution past the last word wraps to address 0.
REQ-025 ALU arithmetic is 32-bit, wraps with no overflow flag; the register write occurs on the same edge as the PC update.
REQ-026 halted = 1 exactly while in HALT.

Reset
REQ-027 With rst_n low at a rising edge: state = FETCH, pc = 0, all registers = 0, gpio_out = 0, instret = 0, halted = 0, IR = 0; imem_req = 0 during that cycle.
REQ-028 Reset asserted in any state, including mid-fetch with imem_ack pending or in HALT, aborts the operation; no write from the aborted instruction occurs.
REQ-029 The first fetch after reset release requests address 0.

Verification
REQ-030 Sequence ADDI x1,x0,5; ADDI x2,x0,3; SUB x3,x1,x2; SW x3; EBREAK with imem_ack always high -> gpio_out = 8'h02, halted = 1, instret = 5, total 10 cycles after reset release.
REQ-031 imem_ack held low for 7 cycles in FETCH -> imem_req stays 1 with imem_addr constant; no state changes; execution resumes correctly once ack is given.
REQ-032 BNE x1,x0,-4 loop with x1 = 1 at the word-2 boundary -> PC alternates between the branch and its target, instret counts up, and gpio_out is unchanged.
REQ-033 ROM_ADDR_BITS = 2, four ADDI x1,x1,1 instructions, fetched without halting -> imem_addr sequence 0,1,2,3,0; x1 = 5 after the fifth retire.
REQ-034 With gpio_in = 8'hA5: LW x4; SW x4 -> gpio_out = 8'hA5; ADDI x0,x0,7 followed by SW x0 -> gpio_out = 0.
REQ-035 rst_n pulsed low for one cycle while in HALT and mid-fetch -> all outputs return to the REQ-027 values on the next edge, and the next fetch requests address 0.
